// File: rtl/patch_lookup.sv
// Patch-table lookup stage: matches accepted addresses against a small programmable
// table and registers {address, match, replacement, data} for the downstream patch mux.
//
// state | meaning
// IDLE  | output register empty, mi_valid_o low
// FULL  | output register holds a result awaiting mi_ready_i
module patch_lookup #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int ENTRIES = 4,
    parameter int IDX_W   = (ENTRIES > 1) ? $clog2(ENTRIES) : 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              cfg_we_i,
    input  logic [IDX_W-1:0]  cfg_idx_i,
    input  logic              cfg_en_i,
    input  logic [ADDR_W-1:0] cfg_match_i,
    input  logic [ADDR_W-1:0] cfg_repl_i,
    input  logic [DATA_W-1:0] cfg_data_i,
    input  logic              cnt_clr_i,
    input  logic              si_valid_i,
    output logic              si_ready_o,
    input  logic [ADDR_W-1:0] si_addr_i,
    output logic              mi_valid_o,
    input  logic              mi_ready_i,
    output logic [ADDR_W-1:0] mi_addr_o,
    output logic              patch_match_o,
    output logic [ADDR_W-1:0] ctl_pat_addr_o,
    output logic [DATA_W-1:0] ctl_pat_data_o,
    output logic [15:0]       hit_cnt_o
);

    typedef enum logic {IDLE, FULL} state_t;

    state_t              state_q;
    logic                en_q    [ENTRIES];
    logic [ADDR_W-1:0]   match_q [ENTRIES];
    logic [ADDR_W-1:0]   repl_q  [ENTRIES];
    logic [DATA_W-1:0]   data_q  [ENTRIES];

    logic                accept;
    logic                hit;
    logic [ADDR_W-1:0]   hit_repl;
    logic [DATA_W-1:0]   hit_data;

    assign mi_valid_o = (state_q == FULL);
    assign si_ready_o = rst_ni && (!mi_valid_o || mi_ready_i);
    assign accept     = si_valid_i && si_ready_o;

    // Descending scan so the lowest matching index is the last one assigned.
    always_comb begin
        hit      = 1'b0;
        hit_repl = '0;
        hit_data = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (en_q[i] && (match_q[i] == si_addr_i)) begin
                hit      = 1'b1;
                hit_repl = repl_q[i];
                hit_data = data_q[i];
            end
        end
    end

    // Index compare per entry drops writes to indices beyond the table.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < ENTRIES; i++) begin
                en_q[i]    <= 1'b0;
                match_q[i] <= '0;
                repl_q[i]  <= '0;
                data_q[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                if (cfg_we_i && (cfg_idx_i == IDX_W'(i))) begin
                    en_q[i]    <= cfg_en_i;
                    match_q[i] <= cfg_match_i;
                    repl_q[i]  <= cfg_repl_i;
                    data_q[i]  <= cfg_data_i;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= IDLE;
            mi_addr_o      <= '0;
            patch_match_o  <= 1'b0;
            ctl_pat_addr_o <= '0;
            ctl_pat_data_o <= '0;
        end else begin
            if (accept) begin
                state_q        <= FULL;
                mi_addr_o      <= si_addr_i;
                patch_match_o  <= hit;
                ctl_pat_addr_o <= hit_repl;
                ctl_pat_data_o <= hit_data;
            end else if (mi_ready_i) begin
                state_q <= IDLE;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hit_cnt_o <= '0;
        end else if (cnt_clr_i) begin
            hit_cnt_o <= '0;
        end else if (accept && hit && (hit_cnt_o != 16'hFFFF)) begin
            hit_cnt_o <= hit_cnt_o + 16'd1;
        end
    end

endmodule
